pipelined_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor. Generalises the team's 4-bit ripple-carry adder to WIDTH bits, split into STAGES register-separated carry chunks.
- Adds a valid/ready handshake with backpressure, a subtract mode and a signed-overflow flag.
- Sits in the datapath wherever wide additions must meet timing at full clock rate.
- Throughput is one operation per cycle; latency is STAGES cycles.

---
 rtl/pipelined_adder_pkg.sv | 18 +
 rtl/adder_chunk.sv | 27 ++
 rtl/pipelined_adder.sv | 125 ++++++++++++
 tb/tb_pipelined_adder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encoding
// and helpers that derive and validate the per-stage chunk width.
package pipelined_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple of full adders; also exposes the carry into the
// chunk's top bit so the last stage can form signed overflow.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  always_comb begin
    logic carry;
    carry    = cin;
    sum      = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb_in = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder/subtractor split into STAGES register-separated carry chunks,
// with a single global advance so a stalled output freezes the whole pipe.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK  = chunk_w(WIDTH, STAGES);
  localparam bit CFG_OK = cfg_ok(WIDTH, STAGES);

  if (!CFG_OK) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be divisible by STAGES and STAGES in 1..WIDTH");
  end

  logic             adv;
  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             ovf_q;

  // Per-stage register outputs, exposed as arrays so stage k can read stage k-1.
  logic [WIDTH-1:0] a_st    [STAGES];
  logic [WIDTH-1:0] b_st    [STAGES];
  logic [WIDTH-1:0] s_st    [STAGES];
  logic             c_st    [STAGES];
  logic             v_st    [STAGES];
  logic             cmsb_st [STAGES];

  assign op       = op_e'(sub);
  assign b_eff    = (op == OP_SUB) ? ~b : b;
  assign c0       = (op == OP_SUB) ? 1'b1 : cin;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_in, v_in;
    logic             c_q, v_q;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    if (gi == 0) begin : g_head
      assign a_in = a;
      assign b_in = b_eff;
      assign c_in = c0;
      assign s_in = '0;
      assign v_in = in_valid;
    end else begin : g_body
      assign a_in = a_st[gi-1];
      assign b_in = b_st[gi-1];
      assign c_in = c_st[gi-1];
      assign s_in = s_st[gi-1];
      assign v_in = v_st[gi-1];
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a        (a_in[gi*CHUNK +: CHUNK]),
      .b        (b_in[gi*CHUNK +: CHUNK]),
      .cin      (c_in),
      .sum      (chunk_sum),
      .cout     (chunk_cout),
      .c_msb_in (cmsb_st[gi])
    );

    always_comb begin
      s_d = s_in;
      s_d[gi*CHUNK +: CHUNK] = chunk_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
        a_q <= a_in;
        b_q <= b_in;
        s_q <= s_d;
        c_q <= chunk_cout;
      end
    end

    if (gi == STAGES - 1) begin : g_ovf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= cmsb_st[gi] ^ chunk_cout;
        end
      end
    end

    assign a_st[gi] = a_q;
    assign b_st[gi] = b_q;
    assign s_st[gi] = s_q;
    assign c_st[gi] = c_q;
    assign v_st[gi] = v_q;
  end

  assign out_valid = v_st[STAGES-1];
  assign sum       = s_st[STAGES-1];
  assign cout      = c_st[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4): queue-based
// arithmetic model checked every output transfer, plus literal expectations.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic        cout, ovf;

  int checks = 0;
  int failures = 0;
  int out_count = 0;

  logic [17:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [17:0] hold_val;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Result = {ovf, cout, sum} from plain 17-bit arithmetic and sign rules.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic c, input logic s);
    logic [15:0] be;
    logic [16:0] full;
    logic        ov;
    be   = s ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + {16'd0, (s ? 1'b1 : c)};
    ov   = (av[15] == be[15]) && (full[15] != av[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  // Compare process: transfers are judged from signals stable at the negedge.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("hold_stable", {13'd0, out_valid, ovf, cout, sum}, {13'd0, 1'b1, hold_val});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("model_sum", {16'd0, sum}, {16'd0, e[15:0]});
          chk("model_cout", {31'd0, cout}, {31'd0, e[16]});
          chk("model_ovf", {31'd0, ovf}, {31'd0, e[17]});
          out_count++;
          $display("out #%0d sum=%h cout=%b ovf=%b", out_count, sum, cout, ovf);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {ovf, cout, sum};
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
    bit ok = 1'b0;
    int n = 0;
    a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    chk("send_accept", {31'd0, ok}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [15:0] av, input logic [15:0] bv,
                         input logic c, input logic s, input logic [15:0] es,
                         input logic ec, input logic eo);
    int lat = 0;
    send(av, bv, c, s);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, STAGES - 1);
    chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_seen"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [15:0] held;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    run_one("basic",  16'h000B, 16'h0007, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0);
    run_one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("cin",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("sub_neg",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("add_ovf",16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_ovf",16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("sub_cin",16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0);

    // Throughput: 8 back-to-back operands, results on 8 consecutive cycles.
    fork
      for (int i = 0; i < 8; i++) send(16'(i), 16'(2 * i), 1'b0, 1'b0);
      begin
        wait_out_valid("thru");
        for (int i = 0; i < 8; i++) begin
          chk("thru_valid", {31'd0, out_valid}, 32'd1);
          chk("thru_sum", {16'd0, sum}, 3 * i);
          if (i < 7) @(negedge clk);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: hold out_ready low for 5 cycles while results are pending.
    base = out_count;
    fork
      for (int i = 0; i < 6; i++) send(16'h0100 + 16'(i), 16'(16 * i), 1'b0, 1'b0);
      begin
        wait_out_valid("bp");
        @(posedge clk); #1;
        out_ready = 1'b0;
        held = sum;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
          chk("bp_hold_sum", {16'd0, sum}, {16'd0, held});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 30 && (exp_q.size() != 0 || out_valid); n++) begin
      @(posedge clk); #1;
    end
    chk("bp_count", out_count - base, 6);

    // Reset before any output of three in-flight operands.
    for (int i = 0; i < 3; i++) send(16'h0040 + 16'(i), 16'h0001, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    run_one("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Reset between clock edges while a result is held at the output.
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_out_valid("async");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_sum", {16'd0, sum}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
